// File: rtl/mul_hilo_sequencer.sv
// Operand capture, settle timing and HI/LO product return around an external
// combinational signed multiplier; owns the architectural HI/LO registers.
module mul_hilo_sequencer #(
  parameter int BITS   = 32,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BITS-1:0]   bus_in,
  input  logic              start,
  input  logic              b_valid,
  output logic [BITS-1:0]   mul_a,
  output logic [BITS-1:0]   mul_b,
  input  logic [2*BITS-1:0] mul_p,
  output logic [BITS-1:0]   bus_out,
  output logic              out_valid,
  output logic              out_sel,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [BITS-1:0]   hi_q,
  output logic [BITS-1:0]   lo_q
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_B,
    S_WAIT,
    S_OUT_LO,
    S_OUT_HI
  } state_t;

  state_t          state, state_nxt;
  logic [BITS-1:0] a_q, b_q;
  logic [2:0]      cnt;
  logic            done_q;
  logic            accept;

  assign accept = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start)      state_nxt = S_GET_B;
      S_GET_B:  if (b_valid)    state_nxt = S_WAIT;
      S_WAIT:   if (cnt == 3'd0) state_nxt = S_OUT_LO;
      S_OUT_LO: if (accept)     state_nxt = S_OUT_HI;
      S_OUT_HI: if (accept)     state_nxt = S_IDLE;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  // Operands only move on their own load events so the multiplier inputs
  // stay stable from the B load through capture and output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      if (state == S_IDLE && start) a_q <= bus_in;
      if (state == S_GET_B && b_valid) begin
        b_q <= bus_in;
        cnt <= 3'(SETTLE);
      end else if (state == S_WAIT && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (state == S_WAIT && cnt == 3'd0) begin
        hi_q <= mul_p[2*BITS-1:BITS];
        lo_q <= mul_p[BITS-1:0];
      end
      done_q <= (state == S_OUT_HI) && out_ready;
    end
  end

  always_comb begin
    bus_out   = '0;
    out_valid = 1'b0;
    out_sel   = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_OUT_LO: begin
        bus_out   = lo_q;
        out_valid = 1'b1;
      end
      S_OUT_HI: begin
        bus_out   = hi_q;
        out_valid = 1'b1;
        out_sel   = 1'b1;
      end
      default: ;
    endcase
  end

  assign mul_a = a_q;
  assign mul_b = b_q;
  assign done  = done_q;

endmodule

// File: tb/tb_mul_hilo_sequencer.sv
// Randomized bench for mul_hilo_sequencer; the multiplier is a behavioural stub
// and expected words come from plain signed arithmetic on the driven operands.
module tb_mul_hilo_sequencer;
  localparam int BITS   = 32;
  localparam int SETTLE = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     bus_in;
  logic            start, b_valid, out_ready;
  logic [31:0]     mul_a, mul_b, bus_out, hi_q, lo_q;
  logic [63:0]     mul_p;
  logic            out_valid, out_sel, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_a, m_b, m_hi, m_lo;

  always #5 clk = ~clk;

  mul_hilo_sequencer #(.BITS(BITS), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .start(start), .b_valid(b_valid),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .bus_out(bus_out),
    .out_valid(out_valid), .out_sel(out_sel), .out_ready(out_ready),
    .busy(busy), .done(done), .hi_q(hi_q), .lo_q(lo_q)
  );

  // Combinational multiplier stub
  assign mul_p = 64'($signed(mul_a)) * 64'($signed(mul_b));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mul_a"}, 64'(mul_a), 64'd0);
    check({tag, "_mul_b"}, 64'(mul_b), 64'd0);
    check({tag, "_bus_out"}, 64'(bus_out), 64'd0);
    check({tag, "_hi"}, 64'(hi_q), 64'd0);
    check({tag, "_lo"}, 64'(lo_q), 64'd0);
    check({tag, "_flags"}, 64'({out_valid, out_sel, busy, done}), 64'd0);
  endtask

  // One full transaction starting from an IDLE cycle; returns in the done cycle.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int gap,
                         input int stall_lo, input int stall_hi, input bit junk);
    logic [63:0] prod;
    start = 1'b1; bus_in = a; b_valid = junk;
    tick();
    m_a = a;
    check("get_b_busy", 64'(busy), 64'd1);
    check("a_load", 64'(mul_a), 64'(m_a));
    check("b_not_loaded_in_idle", 64'(mul_b), 64'(m_b));
    check("get_b_valid", 64'(out_valid), 64'd0);
    start = 1'b0; b_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      start = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      bus_in = $urandom;
      tick();
      check("gap_busy", 64'(busy), 64'd1);
      check("gap_a_stable", 64'(mul_a), 64'(m_a));
      check("gap_valid", 64'(out_valid), 64'd0);
    end
    start = 1'b0; bus_in = b; b_valid = 1'b1;
    tick();
    m_b = b;
    b_valid = 1'b0;
    for (int i = 0; i <= SETTLE; i++) begin
      start = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      bus_in = $urandom;
      check("wait_valid", 64'(out_valid), 64'd0);
      check("wait_hold_hi", 64'(hi_q), 64'(m_hi));
      check("wait_hold_lo", 64'(lo_q), 64'(m_lo));
      check("wait_ops", {mul_a, mul_b}, {m_a, m_b});
      check("wait_done", 64'(done), 64'd0);
      tick();
    end
    start = 1'b0;
    prod = 64'(longint'(int'(a)) * longint'(int'(b)));
    m_hi = prod[63:32];
    m_lo = prod[31:0];
    check("lo_valid", 64'({out_valid, out_sel}), 64'b10);
    check("lo_word", 64'(bus_out), 64'(m_lo));
    check("hilo_regs", {hi_q, lo_q}, {m_hi, m_lo});
    for (int s = 0; s < stall_lo; s++) begin
      out_ready = 1'b0;
      tick();
      check("lo_stall_word", 64'(bus_out), 64'(m_lo));
      check("lo_stall_sel", 64'({out_valid, out_sel}), 64'b10);
    end
    out_ready = 1'b1;
    tick();
    check("hi_valid", 64'({out_valid, out_sel}), 64'b11);
    check("hi_word", 64'(bus_out), 64'(m_hi));
    for (int s = 0; s < stall_hi; s++) begin
      out_ready = 1'b0;
      tick();
      check("hi_stall_word", 64'(bus_out), 64'(m_hi));
      check("hi_stall_sel", 64'({out_valid, out_sel}), 64'b11);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("done_pulse", 64'(done), 64'd1);
    check("done_idle", 64'({busy, out_valid, out_sel}), 64'd0);
    check("done_bus", 64'(bus_out), 64'd0);
    check("done_regs", {hi_q, lo_q}, {m_hi, m_lo});
  endtask

  initial begin
    rst_n = 1'b0; bus_in = '0; start = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    m_a = '0; m_b = '0; m_hi = '0; m_lo = '0;
    tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Abort a transaction while it sits in OUT_LO
    start = 1'b1; bus_in = 32'd5;
    tick();
    start = 1'b0; bus_in = 32'd9; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    repeat (SETTLE + 1) tick();
    check("abort_in_out_lo", 64'({out_valid, out_sel}), 64'b10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_all_zero("abort");
    b_valid = 1'b1; bus_in = 32'd123;
    repeat (3) begin
      tick();
      check("lone_b_valid", 64'({busy, out_valid}), 64'd0);
      check("lone_b_valid_b", 64'(mul_b), 64'd0);
    end
    b_valid = 1'b0;

    run_txn(32'hFFFFFFFD, 32'd7, 0, 0, 0, 1'b0);
    tick();
    check("done_one_cycle", 64'(done), 64'd0);
    run_txn(32'h80000000, 32'h80000000, 1, 0, 0, 1'b0);
    tick();
    run_txn(32'h7FFFFFFF, 32'd2, 0, 0, 0, 1'b0);
    tick();
    run_txn(32'd0, $urandom, 0, 0, 0, 1'b0);
    tick();
    run_txn($urandom, $urandom, 2, 5, 3, 1'b1);
    // Back-to-back: next start lands in the done cycle
    run_txn(32'h12345678, 32'hFEDCBA98, 0, 0, 0, 1'b0);
    run_txn(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 1'b0);
    tick();
    check("done_after_b2b", 64'(done), 64'd0);

    for (int t = 0; t < 25; t++) begin
      run_txn($urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        tick();
        check("rand_done_low", 64'(done), 64'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
